// File: rtl/gain_meter_bcd.sv
// gain_meter_bcd
//   Windowed RMS gain meter. Squares of the pre- and post-processing samples
//   are summed over 2^LOG2_WIN accepted samples. At each window end the two
//   sums are snapshotted and a small sequencer produces the gain
//   10*log10(P_out/P_in) in tenths of dB. The result is shown as three BCD
//   digits plus a sign and a saturation flag.
//
//   Sequencer: IDLE -> LOG -> SCALE -> CLAMP -> BCD (10 cycles) -> UPDATE.
//   The digits update 14 cycles after the snapshot edge.
//
//   Optional build macro GAIN_METER_DBFS_EN adds the input mode_dbfs. When
//   mode_dbfs is 1 at the snapshot, L(in) is replaced by a full-scale
//   reference, so the display shows the output level in dBFS.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   mode_dbfs     (GAIN_METER_DBFS_EN only) dBFS display mode, sampled at snapshot
//   sample_valid  accept in_wave/out_wave on this rising edge
//   in_wave       signed pre-processing sample
//   out_wave      signed post-processing sample
//   num2/1/0      BCD tens / units / tenths of dB
//   neg           gain is negative
//   sat           result was clamped to 99.9 dB magnitude
//   result_valid  one-cycle pulse when the digits update
//   overrun       sticky: a window ended while the sequencer was busy
module gain_meter_bcd #(
   parameter int WIDTH    = 16,
   parameter int LOG2_WIN = 14
) (
   input  logic                    clk,
   input  logic                    reset_n,
`ifdef GAIN_METER_DBFS_EN
   input  logic                    mode_dbfs,
`endif
   input  logic                    sample_valid,
   input  logic signed [WIDTH-1:0] in_wave,
   input  logic signed [WIDTH-1:0] out_wave,
   output logic [3:0]              num2,
   output logic [3:0]              num1,
   output logic [3:0]              num0,
   output logic                    neg,
   output logic                    sat,
   output logic                    result_valid,
   output logic                    overrun
);

   localparam int W2  = 2 * WIDTH;
   localparam int ACC = W2 + LOG2_WIN;
   localparam int IW  = $clog2(ACC);   // integer part of L: MSB index < ACC
   localparam int LW  = IW + 8;        // Q.8 log width
   localparam logic [LW-1:0] L_FULL = LW'((W2 - 2 + LOG2_WIN) << 8);

   typedef enum logic [2:0] {S_IDLE, S_LOG, S_SCALE, S_CLAMP, S_BCD, S_UPDATE} state_t;

   // Integer log2 in Q.8. The fraction is the 8 bits just below the MSB.
   // Shifting {x, 8'b0} right by the MSB index places those bits at [7:0]
   // and zero-pads when the MSB is below bit 8.
   function automatic logic [LW-1:0] log2_q8(input logic [ACC-1:0] x);
      int msb;
      logic [ACC+7:0] t;
      msb = 0;
      for (int i = 0; i < ACC; i++) begin
         if (x[i]) msb = i;
      end
      t = {x, 8'b0} >> msb;
      return {IW'(msb), t[7:0]};
   endfunction

   // One double-dabble iteration on {bcd[11:0], bin[9:0]}.
   function automatic logic [21:0] dabble_step(input logic [21:0] v);
      logic [21:0] r;
      r = v;
      for (int k = 0; k < 3; k++) begin
         if (r[10+4*k +: 4] >= 4'd5) r[10+4*k +: 4] = r[10+4*k +: 4] + 4'd3;
      end
      return {r[20:0], 1'b0};
   endfunction

   // ---------------- accumulation ----------------
   logic [ACC-1:0]      acc_in_q, acc_out_q, acc_in_d, acc_out_d;
   logic [LOG2_WIN-1:0] cnt_q;
   logic [W2-1:0]       sq_in, sq_out;
   logic                win_end;
   logic                mode_sel;

   // Signed squares are non-negative and fit in 2*WIDTH bits,
   // including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
   assign sq_in     = W2'(W2'(in_wave) * W2'(in_wave));
   assign sq_out    = W2'(W2'(out_wave) * W2'(out_wave));
   assign acc_in_d  = acc_in_q + ACC'(sq_in);
   assign acc_out_d = acc_out_q + ACC'(sq_out);
   assign win_end   = sample_valid && (&cnt_q);

`ifdef GAIN_METER_DBFS_EN
   assign mode_sel = mode_dbfs;
`else
   assign mode_sel = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_in_q  <= '0;
         acc_out_q <= '0;
         cnt_q     <= '0;
      end else if (sample_valid) begin
         cnt_q <= cnt_q + 1'b1;   // wraps to 0 on the window's last sample
         if (win_end) begin
            acc_in_q  <= '0;
            acc_out_q <= '0;
         end else begin
            acc_in_q  <= acc_in_d;
            acc_out_q <= acc_out_d;
         end
      end
   end

   // ---------------- conversion sequencer ----------------
   state_t           state_q;
   logic [ACC-1:0]   snap_in_q, snap_out_q;
   logic             dbfs_q, in_zero_q, out_zero_q;
   logic [LW:0]      d_q;
   logic [11:0]      m_q;
   logic             neg_q, sat_q;
   logic [21:0]      dd_q;
   logic [3:0]       step_q;

   logic [LW-1:0]    l_in, l_out;
   logic [LW:0]      d_d, d_abs;
   logic [31:0]      prod;
   logic [11:0]      m_calc, m_clamp;
   logic             unused_ok;

   assign l_in    = dbfs_q ? L_FULL : log2_q8(snap_in_q);
   assign l_out   = log2_q8(snap_out_q);
   assign d_d     = {1'b0, l_out} - {1'b0, l_in};
   assign d_abs   = d_q[LW] ? -d_q : d_q;
   // 7706 = round(10*log10(2)*10*256): Q.8 log2 difference -> tenths of dB.
   assign prod    = 32'(d_abs) * 32'd7706 + 32'd32768;
   assign m_calc  = prod[27:16];
   assign m_clamp = (m_q > 12'd999) ? 12'd999 : m_q;
   assign unused_ok = &{1'b0, prod[31:28], prod[15:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         snap_in_q    <= '0;
         snap_out_q   <= '0;
         dbfs_q       <= 1'b0;
         in_zero_q    <= 1'b0;
         out_zero_q   <= 1'b0;
         d_q          <= '0;
         m_q          <= '0;
         neg_q        <= 1'b0;
         sat_q        <= 1'b0;
         dd_q         <= '0;
         step_q       <= '0;
         num2         <= '0;
         num1         <= '0;
         num0         <= '0;
         neg          <= 1'b0;
         sat          <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         // A window ending mid-conversion is dropped; the running result continues.
         if (win_end && state_q != S_IDLE) overrun <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (win_end) begin
                  snap_in_q  <= acc_in_d;    // includes the window's last sample
                  snap_out_q <= acc_out_d;
                  dbfs_q     <= mode_sel;
                  state_q    <= S_LOG;
               end
            end
            S_LOG: begin
               d_q        <= d_d;
               in_zero_q  <= !dbfs_q && (snap_in_q == '0);
               out_zero_q <= (snap_out_q == '0);
               state_q    <= S_SCALE;
            end
            S_SCALE: begin
               if (in_zero_q && out_zero_q) begin
                  m_q <= 12'd0;   sat_q <= 1'b0; neg_q <= 1'b0;
               end else if (in_zero_q) begin
                  m_q <= 12'd999; sat_q <= 1'b1; neg_q <= 1'b0;
               end else if (out_zero_q) begin
                  m_q <= 12'd999; sat_q <= 1'b1; neg_q <= 1'b1;
               end else begin
                  m_q <= m_calc;  sat_q <= 1'b0; neg_q <= d_q[LW];
               end
               state_q <= S_CLAMP;
            end
            S_CLAMP: begin
               if (m_q > 12'd999) sat_q <= 1'b1;
               if (m_clamp == 12'd0) neg_q <= 1'b0;   // no negative zero
               m_q     <= m_clamp;
               dd_q    <= {12'b0, m_clamp[9:0]};
               step_q  <= '0;
               state_q <= S_BCD;
            end
            S_BCD: begin
               dd_q   <= dabble_step(dd_q);
               step_q <= step_q + 1'b1;
               if (step_q == 4'd9) state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               num2         <= dd_q[21:18];
               num1         <= dd_q[17:14];
               num0         <= dd_q[13:10];
               neg          <= neg_q;
               sat          <= sat_q;
               result_valid <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gain_meter_bcd.sv
// Testbench for gain_meter_bcd (WIDTH=16, LOG2_WIN=4, default build).
// A reference model keeps the window sums as plain integers. It computes the
// expected display value from the log2/dB rules with integer arithmetic and
// schedules each result 14 cycles after the window's last sample. Every cycle
// the bench checks either the expected pulse and digits or that no pulse occurs.
module tb_gain_meter_bcd;
   localparam int WIDTH    = 16;
   localparam int LOG2_WIN = 4;
   localparam int WIN      = 1 << LOG2_WIN;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sample_valid = 1'b0;
   logic signed [WIDTH-1:0] in_wave = '0;
   logic signed [WIDTH-1:0] out_wave = '0;
   logic [3:0] num2, num1, num0;
   logic neg, sat, result_valid, overrun;

   always #5 clk = ~clk;

   gain_meter_bcd #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) dut (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
      .in_wave(in_wave), .out_wave(out_wave),
      .num2(num2), .num1(num1), .num0(num0),
      .neg(neg), .sat(sat), .result_valid(result_valid), .overrun(overrun)
   );

   typedef struct {int due; int m; bit ng; bit st;} exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cnt = 0;
   int pulses = 0;
   int windows = 0;
   longint sum_in = 0;
   longint sum_out = 0;

   // Q.8 log2: floor(log2 x) plus the truncated fraction of x / 2^msb.
   function automatic longint lq8(longint x);
      int msb = 0;
      longint t = x;
      while (t > 1) begin
         t = t >> 1;
         msb++;
      end
      return longint'(msb) * 256 + ((x * 256) >> msb) - 256;
   endfunction

   function automatic exp_t expect_of(longint si, longint so, int due);
      exp_t e;
      longint d, ad, m;
      e.due = due;
      if (si == 0 && so == 0) begin
         e.m = 0; e.ng = 0; e.st = 0;
      end else if (si == 0) begin
         e.m = 999; e.ng = 0; e.st = 1;
      end else if (so == 0) begin
         e.m = 999; e.ng = 1; e.st = 1;
      end else begin
         d  = lq8(so) - lq8(si);
         ad = (d < 0) ? -d : d;
         m  = (ad * 7706 + 32768) / 65536;
         e.st = (m > 999);
         if (m > 999) m = 999;
         e.m  = int'(m);
         e.ng = (d < 0) && (m != 0);
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(bit v, logic signed [WIDTH-1:0] a, logic signed [WIDTH-1:0] b);
      exp_t e;
      sample_valid = v;
      in_wave = a;
      out_wave = b;
      @(posedge clk);
      #1;
      cyc++;
      if (v && reset_n) begin
         sum_in  += longint'(a) * longint'(a);
         sum_out += longint'(b) * longint'(b);
         cnt++;
         if (cnt == WIN) begin
            q.push_back(expect_of(sum_in, sum_out, cyc + 14));
            windows++;
            sum_in = 0; sum_out = 0; cnt = 0;
         end
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         pulses++;
         chk("result_valid", 64'(result_valid), 64'd1);
         chk("num2", 64'(num2), 64'(e.m / 100));
         chk("num1", 64'(num1), 64'((e.m / 10) % 10));
         chk("num0", 64'(num0), 64'(e.m % 10));
         chk("neg", 64'(neg), 64'(e.ng));
         chk("sat", 64'(sat), 64'(e.st));
         chk("overrun", 64'(overrun), 64'd0);
         $display("result m=%0d neg=%0d sat=%0d at cycle %0d", e.m, e.ng, e.st, cyc);
      end else begin
         chk("result_valid_idle", 64'(result_valid), 64'd0);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   task automatic window(logic signed [WIDTH-1:0] a, logic signed [WIDTH-1:0] b);
      for (int i = 0; i < WIN; i++) step(1'b1, a, b);
   endtask

   task automatic check_cleared(string tag);
      chk({tag, "_num"}, 64'({num2, num1, num0}), 64'd0);
      chk({tag, "_flags"}, 64'({neg, sat, result_valid, overrun}), 64'd0);
   endtask

   function automatic logic signed [WIDTH-1:0] rnd(int k);
      int mag;
      mag = int'($urandom_range(0, (1 << k) - 1));
      return ($urandom_range(0, 1) == 1) ? WIDTH'(-mag) : WIDTH'(mag);
   endfunction

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      reset_n = 1'b1;

      // equal levels -> 00.0
      window(16'sd1000, 16'sd1000);
      idle(16);
      // +6.0 dB with alternating output sign
      for (int i = 0; i < WIN; i++) step(1'b1, 16'sd1000, (i % 2 == 1) ? -16'sd2000 : 16'sd2000);
      idle(16);
      // -6.0 dB
      window(16'sd2000, 16'sd1000);
      idle(16);
      // silent input -> +99.9 sat, then silence both -> 00.0
      window(16'sd0, 16'sd1000);
      window(16'sd0, 16'sd0);
      idle(16);
      // most negative input squared; tiny output -> below -99.9, clamped
      step(1'b1, -16'sd32768, 16'sd1);
      for (int i = 1; i < WIN; i++) step(1'b1, -16'sd32768, 16'sd0);
      idle(16);
      // both channels at most negative value -> 00.0
      window(-16'sd32768, -16'sd32768);
      idle(16);

      // reset mid-window discards partial sums
      for (int i = 0; i < 8; i++) step(1'b1, 16'sd3000, 16'sd5);
      reset_n = 1'b0;
      q.delete();
      sum_in = 0; sum_out = 0; cnt = 0;
      #1;
      check_cleared("midreset");
      idle(2);
      reset_n = 1'b1;
      window(16'sd1000, 16'sd2000);
      idle(16);

      // gapped strobe: 1 sample every 3 cycles over 3 windows
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < WIN; i++) begin
            step(1'b1, rnd(8 + w), rnd(10 + w));
            idle(2);
         end
      end
      idle(16);

      // randomized windows with random scales and random gaps
      for (int w = 0; w < 12; w++) begin
         int ka, kb, gap;
         ka = int'($urandom_range(0, 15));
         kb = int'($urandom_range(0, 15));
         for (int i = 0; i < WIN; i++) begin
            step(1'b1, rnd(ka), rnd(kb));
            gap = int'($urandom_range(0, 2));
            idle(gap);
         end
      end

      idle(20);
      chk("pending_results", 64'(q.size()), 64'd0);
      chk("pulse_count", 64'(pulses), 64'(windows));
      chk("overrun_final", 64'(overrun), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
